// File: rtl/tm1638_pkg.sv
// Shared types and constants for the TM1638 device-side responder.
package tm1638_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WRITE,
    READ,
    IGNORE
  } state_e;

  localparam logic [1:0] CMD_DATA = 2'b01;
  localparam logic [1:0] CMD_CTRL = 2'b10;
  localparam logic [1:0] CMD_ADDR = 2'b11;

  localparam int READ_BIT  = 1;
  localparam int FIXED_BIT = 2;
  localparam int RAM_DEPTH = 16;

  // Key-scan byte j: bit0 = keys[7-j], bit4 = keys[3-j]; bytes past the 4th are zero.
  function automatic logic [7:0] key_byte(input logic [7:0] k, input logic [2:0] idx);
    case (idx)
      3'd0:    key_byte = {3'b000, k[3], 3'b000, k[7]};
      3'd1:    key_byte = {3'b000, k[2], 3'b000, k[6]};
      3'd2:    key_byte = {3'b000, k[1], 3'b000, k[5]};
      3'd3:    key_byte = {3'b000, k[0], 3'b000, k[4]};
      default: key_byte = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/tm1638_bit_shifter.sv
// Input synchronizers, edge detection, LSB-first receive shifter and
// fall-advanced transmit shifter for the TM1638 serial link.
module tm1638_bit_shifter #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tm_strobe,
  input  logic       tm_clock,
  input  logic       tm_dio_in,
  input  logic       rx_enable,
  input  logic       tx_enable,
  input  logic [7:0] tx_data,
  output logic       stb_fall,
  output logic       stb_rise,
  output logic       clk_fall,
  output logic       byte_done,
  output logic [7:0] rx_byte,
  output logic       tx_load,
  output logic       tx_bit
);

  logic [SYNC_STAGES-1:0] stb_sync_q, stb_sync_d;
  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] dio_sync_q, dio_sync_d;
  logic                   stb_prev_q, stb_prev_d;
  logic                   clk_prev_q, clk_prev_d;
  logic [7:0]             rx_shift_q, rx_shift_d;
  logic [2:0]             rx_cnt_q, rx_cnt_d;
  logic                   byte_done_q, byte_done_d;
  logic [7:0]             tx_shift_q, tx_shift_d;
  logic [2:0]             tx_cnt_q, tx_cnt_d;
  logic                   tx_started_q, tx_started_d;
  logic                   stb_s, clk_s, dio_s, clk_rise;

  assign stb_s = stb_sync_q[SYNC_STAGES-1];
  assign clk_s = clk_sync_q[SYNC_STAGES-1];
  assign dio_s = dio_sync_q[SYNC_STAGES-1];

  // Clock edges only count while STB is low, which also lets an STB rise win a tie.
  assign stb_fall = stb_prev_q & ~stb_s;
  assign stb_rise = ~stb_prev_q & stb_s;
  assign clk_rise = ~clk_prev_q & clk_s & ~stb_s;
  assign clk_fall = clk_prev_q & ~clk_s & ~stb_s;

  assign tx_load   = tx_enable & clk_fall & (~tx_started_q | (tx_cnt_q == 3'd7));
  assign byte_done = byte_done_q;
  assign rx_byte   = rx_shift_q;
  assign tx_bit    = tx_shift_q[0];

  always_comb begin
    stb_sync_d   = {stb_sync_q[SYNC_STAGES-2:0], tm_strobe};
    clk_sync_d   = {clk_sync_q[SYNC_STAGES-2:0], tm_clock};
    dio_sync_d   = {dio_sync_q[SYNC_STAGES-2:0], tm_dio_in};
    stb_prev_d   = stb_s;
    clk_prev_d   = clk_s;
    rx_shift_d   = rx_shift_q;
    rx_cnt_d     = rx_cnt_q;
    byte_done_d  = 1'b0;
    tx_shift_d   = tx_shift_q;
    tx_cnt_d     = tx_cnt_q;
    tx_started_d = tx_started_q;

    if (stb_fall || stb_rise) begin
      rx_cnt_d     = 3'd0;
      tx_shift_d   = 8'h00;
      tx_cnt_d     = 3'd0;
      tx_started_d = 1'b0;
    end else begin
      if (clk_rise && rx_enable) begin
        rx_shift_d  = {dio_s, rx_shift_q[7:1]};
        rx_cnt_d    = rx_cnt_q + 3'd1;
        byte_done_d = (rx_cnt_q == 3'd7);
      end
      if (tx_enable && clk_fall) begin
        if (tx_load) begin
          tx_shift_d   = tx_data;
          tx_cnt_d     = 3'd0;
          tx_started_d = 1'b1;
        end else begin
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_cnt_d   = tx_cnt_q + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stb_sync_q   <= '1;
      clk_sync_q   <= '1;
      dio_sync_q   <= '0;
      stb_prev_q   <= 1'b1;
      clk_prev_q   <= 1'b1;
      rx_shift_q   <= 8'h00;
      rx_cnt_q     <= 3'd0;
      byte_done_q  <= 1'b0;
      tx_shift_q   <= 8'h00;
      tx_cnt_q     <= 3'd0;
      tx_started_q <= 1'b0;
    end else begin
      stb_sync_q   <= stb_sync_d;
      clk_sync_q   <= clk_sync_d;
      dio_sync_q   <= dio_sync_d;
      stb_prev_q   <= stb_prev_d;
      clk_prev_q   <= clk_prev_d;
      rx_shift_q   <= rx_shift_d;
      rx_cnt_q     <= rx_cnt_d;
      byte_done_q  <= byte_done_d;
      tx_shift_q   <= tx_shift_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_started_q <= tx_started_d;
    end
  end

endmodule

// File: rtl/tm1638_responder.sv
// TM1638 slave: command decode, 16-byte display RAM, display/LED mapping
// and key-scan readback.
module tm1638_responder
  import tm1638_pkg::*;
#(
  parameter int         SYNC_STAGES      = 2,
  parameter logic [2:0] RESET_BRIGHTNESS = 3'd0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tm_strobe,
  input  logic       tm_clock,
  input  logic       tm_dio_in,
  output logic       tm_dio_out,
  output logic       tm_dio_oe,
  input  logic [7:0] keys,
  output logic [7:0] display0,
  output logic [7:0] display1,
  output logic [7:0] display2,
  output logic [7:0] display3,
  output logic [7:0] display4,
  output logic [7:0] display5,
  output logic [7:0] display6,
  output logic [7:0] display7,
  output logic [7:0] leds,
  output logic       display_on,
  output logic [2:0] brightness,
  output logic       frame_strobe
);

  state_e     state_q, state_d;
  logic [3:0] addr_q, addr_d;
  logic       fixed_q, fixed_d;
  logic [7:0] ram_q [RAM_DEPTH];
  logic [7:0] ram_d [RAM_DEPTH];
  logic       on_q, on_d;
  logic [2:0] bright_q, bright_d;
  logic       oe_q, oe_d;
  logic       wrote_q, wrote_d;
  logic       frame_q, frame_d;
  logic [7:0] keys_q, keys_d;
  logic [2:0] rd_idx_q, rd_idx_d;
  logic [7:0] disp [8];

  logic       stb_fall, stb_rise, clk_fall, byte_done, tx_load, tx_bit;
  logic [7:0] rx_byte;

  tm1638_bit_shifter #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_shifter (
    .clock     (clock),
    .reset     (reset),
    .tm_strobe (tm_strobe),
    .tm_clock  (tm_clock),
    .tm_dio_in (tm_dio_in),
    .rx_enable (~oe_q),
    .tx_enable (state_q == READ),
    .tx_data   (key_byte(keys_q, rd_idx_q)),
    .stb_fall  (stb_fall),
    .stb_rise  (stb_rise),
    .clk_fall  (clk_fall),
    .byte_done (byte_done),
    .rx_byte   (rx_byte),
    .tx_load   (tx_load),
    .tx_bit    (tx_bit)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    fixed_d  = fixed_q;
    ram_d    = ram_q;
    on_d     = on_q;
    bright_d = bright_q;
    oe_d     = oe_q;
    wrote_d  = wrote_q;
    frame_d  = 1'b0;
    keys_d   = keys_q;
    rd_idx_d = rd_idx_q;

    if (stb_fall) begin
      state_d  = CMD;
      wrote_d  = 1'b0;
      rd_idx_d = 3'd0;
    end else if (stb_rise) begin
      // A half-received byte is simply dropped; only completed writes flag a frame.
      state_d = IDLE;
      oe_d    = 1'b0;
      frame_d = wrote_q;
    end else begin
      case (state_q)
        CMD: begin
          if (byte_done) begin
            case (rx_byte[7:6])
              CMD_DATA: begin
                fixed_d = rx_byte[FIXED_BIT];
                if (rx_byte[READ_BIT]) begin
                  state_d = READ;
                  keys_d  = keys;
                end else begin
                  state_d = IGNORE;
                end
              end
              CMD_CTRL: begin
                on_d     = rx_byte[3];
                bright_d = rx_byte[2:0];
                state_d  = IGNORE;
              end
              CMD_ADDR: begin
                addr_d  = rx_byte[3:0];
                state_d = WRITE;
              end
              default: state_d = IGNORE;
            endcase
          end
        end
        WRITE: begin
          if (byte_done) begin
            ram_d[addr_q] = rx_byte;
            wrote_d       = 1'b1;
            if (!fixed_q) addr_d = addr_q + 4'd1;
          end
        end
        READ: begin
          if (clk_fall) oe_d = 1'b1;
          if (tx_load && rd_idx_q != 3'd4) rd_idx_d = rd_idx_q + 3'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      addr_q   <= 4'd0;
      fixed_q  <= 1'b0;
      ram_q    <= '{default: 8'h00};
      on_q     <= 1'b0;
      bright_q <= RESET_BRIGHTNESS;
      oe_q     <= 1'b0;
      wrote_q  <= 1'b0;
      frame_q  <= 1'b0;
      keys_q   <= 8'h00;
      rd_idx_q <= 3'd0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      fixed_q  <= fixed_d;
      ram_q    <= ram_d;
      on_q     <= on_d;
      bright_q <= bright_d;
      oe_q     <= oe_d;
      wrote_q  <= wrote_d;
      frame_q  <= frame_d;
      keys_q   <= keys_d;
      rd_idx_q <= rd_idx_d;
    end
  end

  // Even addresses feed the digits (display7 first); bit 0 of odd addresses feeds the LEDs.
  always_comb begin
    disp = '{default: 8'h00};
    leds = 8'h00;
    for (int k = 0; k < 8; k++) begin
      disp[7-k] = ram_q[2*k];
      leds[7-k] = ram_q[2*k+1][0];
    end
  end

  assign display0     = disp[0];
  assign display1     = disp[1];
  assign display2     = disp[2];
  assign display3     = disp[3];
  assign display4     = disp[4];
  assign display5     = disp[5];
  assign display6     = disp[6];
  assign display7     = disp[7];
  assign display_on   = on_q;
  assign brightness   = bright_q;
  assign tm_dio_oe    = oe_q;
  assign tm_dio_out   = tx_bit;
  assign frame_strobe = frame_q;

endmodule

// File: tb/tb_tm1638_responder.sv
// Self-checking bench: a TM1638 master model drives directed and random
// transactions; a byte-level model of the device predicts outputs and key bytes.
module tb_tm1638_responder;

  localparam int H = 6;  // master half-period in system clocks

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       tm_strobe = 1'b1;
  logic       tm_clock = 1'b1;
  logic       dio_m = 1'b0;
  logic [7:0] keys = 8'h00;
  logic       tm_dio_in, tm_dio_out, tm_dio_oe;
  logic [7:0] display0, display1, display2, display3;
  logic [7:0] display4, display5, display6, display7;
  logic [7:0] leds;
  logic       display_on;
  logic [2:0] brightness;
  logic       frame_strobe;

  int tests = 0;
  int fails = 0;
  int frame_cnt = 0;
  int oe_cycles = 0;

  logic [7:0] m_ram [16];
  logic       m_fixed;
  logic       m_on;
  logic [2:0] m_bright;

  assign tm_dio_in = tm_dio_oe ? tm_dio_out : dio_m;

  tm1638_responder dut (
    .clock        (clock),
    .reset        (reset),
    .tm_strobe    (tm_strobe),
    .tm_clock     (tm_clock),
    .tm_dio_in    (tm_dio_in),
    .tm_dio_out   (tm_dio_out),
    .tm_dio_oe    (tm_dio_oe),
    .keys         (keys),
    .display0     (display0),
    .display1     (display1),
    .display2     (display2),
    .display3     (display3),
    .display4     (display4),
    .display5     (display5),
    .display6     (display6),
    .display7     (display7),
    .leds         (leds),
    .display_on   (display_on),
    .brightness   (brightness),
    .frame_strobe (frame_strobe)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (frame_strobe) frame_cnt <= frame_cnt + 1;
    if (tm_dio_oe) oe_cycles <= oe_cycles + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clock);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_ram[i] = 8'h00;
    m_fixed  = 1'b0;
    m_on     = 1'b0;
    m_bright = 3'd0;
  endtask

  // Byte-level effect of one write-direction transaction.
  task automatic model_apply(input logic [7:0] q[$]);
    logic [7:0] c;
    logic [3:0] a;
    c = q[0];
    if (c >= 8'h40 && c <= 8'h7F) m_fixed = c[2];
    else if (c >= 8'h80 && c <= 8'hBF) begin
      m_on     = c[3];
      m_bright = c[2:0];
    end else if (c >= 8'hC0) begin
      a = c[3:0];
      for (int i = 1; i < q.size(); i++) begin
        m_ram[a] = q[i];
        if (!m_fixed) a = a + 4'd1;
      end
    end
  endtask

  function automatic logic [7:0] exp_read(input logic [7:0] k, input int j);
    logic [7:0] r;
    r = 8'h00;
    if (j < 4) begin
      r[0] = k[7-j];
      r[4] = k[3-j];
    end
    return r;
  endfunction

  task automatic check_outputs(input string tag);
    logic [63:0] od, ed;
    logic [7:0]  el;
    @(negedge clock);
    od = {display7, display6, display5, display4, display3, display2, display1, display0};
    for (int n = 0; n < 8; n++) ed[8*n +: 8] = m_ram[2*(7-n)];
    for (int k = 0; k < 8; k++) el[7-k] = m_ram[2*k+1][0];
    check({tag, ".disp"}, od, ed);
    check({tag, ".leds"}, 64'(leds), 64'(el));
    check({tag, ".ctrl"}, 64'({display_on, brightness}), 64'({m_on, m_bright}));
  endtask

  task automatic stb_lo();
    tm_strobe = 1'b0;
    wait_cyc(H);
  endtask

  task automatic stb_hi();
    wait_cyc(H);
    tm_strobe = 1'b1;
    wait_cyc(3 * H);
  endtask

  task automatic send_bits(input logic [7:0] b, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      tm_clock = 1'b0;
      dio_m    = b[i];
      wait_cyc(H);
      tm_clock = 1'b1;
      wait_cyc(H);
    end
  endtask

  task automatic read_byte(output logic [7:0] b, output bit ok);
    ok = 1'b1;
    b  = 8'h00;
    for (int i = 0; i < 8; i++) begin
      tm_clock = 1'b0;
      wait_cyc(H);
      @(negedge clock);
      b[i] = tm_dio_in;
      ok   = ok & tm_dio_oe;
      tm_clock = 1'b1;
      wait_cyc(H);
    end
  endtask

  task automatic write_xact(input string tag, input logic [7:0] q[$]);
    int f0, o0;
    logic wr;
    f0 = frame_cnt;
    o0 = oe_cycles;
    stb_lo();
    foreach (q[i]) send_bits(q[i], 8);
    stb_hi();
    wr = (q[0] >= 8'hC0) && (q.size() > 1);
    check({tag, ".frame"}, 64'(frame_cnt - f0), 64'(wr));
    check({tag, ".oe_idle"}, 64'(oe_cycles - o0), 64'd0);
    model_apply(q);
    check_outputs(tag);
  endtask

  task automatic read_xact(input string tag, input logic [7:0] cmd, input int nb, input logic [7:0] k);
    logic [7:0] b;
    bit ok;
    int f0;
    f0   = frame_cnt;
    keys = k;
    stb_lo();
    send_bits(cmd, 8);
    keys = ~k;
    @(negedge clock);
    check({tag, ".oe_pre"}, 64'(tm_dio_oe), 64'd0);
    for (int j = 0; j < nb; j++) begin
      read_byte(b, ok);
      check($sformatf("%s.byte%0d", tag, j), 64'(b), 64'(exp_read(k, j)));
      check($sformatf("%s.oe%0d", tag, j), 64'(ok), 64'd1);
    end
    stb_hi();
    @(negedge clock);
    check({tag, ".oe_post"}, 64'(tm_dio_oe), 64'd0);
    check({tag, ".frame"}, 64'(frame_cnt - f0), 64'd0);
    m_fixed = cmd[2];
    check_outputs(tag);
  endtask

  initial begin
    logic [7:0] qq[$];
    logic [7:0] cmd, b;
    int kind, n, f0;
    bit ok;

    model_reset();
    wait_cyc(5);
    @(negedge clock);
    check("reset.oe", 64'(tm_dio_oe), 64'd0);
    check("reset.dio", 64'(tm_dio_out), 64'd0);
    reset = 1'b1;
    wait_cyc(4);
    check("reset.frame", 64'(frame_strobe), 64'd0);
    check_outputs("reset");

    qq.delete(); qq.push_back(8'h8D);
    write_xact("ctrl", qq);
    check("ctrl.on_bright", 64'({display_on, brightness}), 64'({1'b1, 3'd5}));

    qq.delete(); qq.push_back(8'h40);
    write_xact("dcmd_auto", qq);
    qq.delete(); qq.push_back(8'hC0);
    qq.push_back(8'h3F); qq.push_back(8'h01); qq.push_back(8'h06); qq.push_back(8'h00);
    for (int i = 0; i < 12; i++) qq.push_back(8'($urandom));
    write_xact("full16", qq);
    check("full16.d7", 64'(display7), 64'h3F);
    check("full16.led7", 64'(leds[7]), 64'd1);
    check("full16.d6", 64'(display6), 64'h06);
    check("full16.led6", 64'(leds[6]), 64'd0);

    qq.delete(); qq.push_back(8'h44);
    write_xact("dcmd_fixed", qq);
    qq.delete(); qq.push_back(8'hCE); qq.push_back(8'h11); qq.push_back(8'h22);
    write_xact("fixed", qq);
    check("fixed.d0", 64'(display0), 64'h22);
    qq.delete(); qq.push_back(8'h40);
    write_xact("dcmd_auto2", qq);
    qq.delete(); qq.push_back(8'hCF); qq.push_back(8'h01); qq.push_back(8'hAA);
    write_xact("wrap", qq);
    check("wrap.led0", 64'(leds[0]), 64'd1);
    check("wrap.d7", 64'(display7), 64'hAA);

    read_xact("read81", 8'h42, 4, 8'h81);

    // STB rises after three bits of a data byte: nothing is written.
    f0 = frame_cnt;
    stb_lo();
    send_bits(8'hC3, 8);
    send_bits(8'hFF, 3);
    stb_hi();
    check("abort.frame", 64'(frame_cnt - f0), 64'd0);
    check_outputs("abort");
    qq.delete(); qq.push_back(8'hC6); qq.push_back(8'h5B);
    write_xact("after_abort", qq);

    // Eighth rising edge coincides with STB rise: the edge loses.
    f0 = frame_cnt;
    stb_lo();
    send_bits(8'hC5, 8);
    send_bits(8'hE7, 7);
    tm_clock = 1'b0;
    dio_m    = 1'b1;
    wait_cyc(H);
    tm_clock  = 1'b1;
    tm_strobe = 1'b1;
    wait_cyc(3 * H);
    check("tie.frame", 64'(frame_cnt - f0), 64'd0);
    check_outputs("tie");

    for (int t = 0; t < 30; t++) begin
      kind = int'($urandom_range(0, 4));
      qq.delete();
      case (kind)
        0: begin
          qq.push_back(8'h40 | (8'($urandom) & 8'h3D));
          write_xact("rnd_dcmd", qq);
        end
        1: begin
          qq.push_back(8'h80 | (8'($urandom) & 8'h3F));
          write_xact("rnd_ctrl", qq);
        end
        2: begin
          qq.push_back(8'hC0 | (8'($urandom) & 8'h3F));
          n = int'($urandom_range(1, 6));
          for (int i = 0; i < n; i++) qq.push_back(8'($urandom));
          write_xact("rnd_addr", qq);
        end
        3: begin
          cmd = 8'h42 | (8'($urandom) & 8'h3D);
          read_xact("rnd_read", cmd, int'($urandom_range(1, 5)), 8'($urandom));
        end
        default: begin
          qq.push_back(8'($urandom) & 8'h3F);
          n = int'($urandom_range(0, 2));
          for (int i = 0; i < n; i++) qq.push_back(8'($urandom));
          write_xact("rnd_junk", qq);
        end
      endcase
    end

    // Reset asserted while the responder is driving DIO.
    keys = 8'h5A;
    stb_lo();
    send_bits(8'h42, 8);
    read_byte(b, ok);
    tm_clock = 1'b0;
    wait_cyc(H);
    @(negedge clock);
    check("rst_mid.oe_before", 64'(tm_dio_oe), 64'd1);
    #2 reset = 1'b0;
    #1;
    check("rst_mid.oe", 64'(tm_dio_oe), 64'd0);
    check("rst_mid.dio", 64'(tm_dio_out), 64'd0);
    check("rst_mid.frame", 64'(frame_strobe), 64'd0);
    model_reset();
    check_outputs("rst_mid");
    tm_strobe = 1'b1;
    tm_clock  = 1'b1;
    wait_cyc(4);
    @(negedge clock);
    reset = 1'b1;
    wait_cyc(6);
    qq.delete(); qq.push_back(8'hC2); qq.push_back(8'h77); qq.push_back(8'h01);
    write_xact("post_reset", qq);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tm1638_responder.md
Name: tm1638_responder

Overview:
Device-side (slave) model of the TM1638 serial protocol, the opposite end of the ledandkey controller. It receives STB/CLK/DIO from a TM1638 master and decodes data, display-control and address commands. It keeps the 16-byte display RAM, exposes that RAM as display/LED outputs, and shifts key-scan bytes back on read commands. It is used for FPGA-to-FPGA TM1638 emulation and as a loopback target for controller verification.

Parameters:
SYNC_STAGES, 2, flops in the input synchronizers on tm_strobe, tm_clock and tm_dio_in (minimum 2)
RESET_BRIGHTNESS, 0, brightness value loaded at reset (3 bits)

Ports:
clock  input  1  master clock
reset  input  1  asynchronous, active-low reset
tm_strobe  input  1  STB from master, active low
tm_clock  input  1  CLK from master
tm_dio_in  input  1  DIO pin value (from SB_IO D_IN_0 at top level)
tm_dio_out  output  1  DIO drive value
tm_dio_oe  output  1  DIO output enable; 1 = responder drives pin
keys  input  8  key states (1 = pressed), sampled at read-command completion
display0..display7  output  8 each  seven-segment bytes
leds  output  8  LED bits
display_on  output  1  display-control on bit
brightness  output  3  display-control brightness
frame_strobe  output  1  one-cycle pulse at STB rise when the transaction wrote at least one RAM byte

Behaviour:
- Reset (reset = 0, async): RAM all 0x00; display_on = 0; brightness = RESET_BRIGHTNESS; tm_dio_oe = 0; tm_dio_out = 0; frame_strobe = 0; state IDLE; mode = write, auto-increment; address = 0.
- Inputs pass through SYNC_STAGES flops. Edges are detected on the synchronized signals. The tm_clock high and low phases must each be at least SYNC_STAGES+2 clock cycles.
- Bit order is LSB first. A DIO bit is sampled on each detected tm_clock rising edge while STB is low and the responder is not driving. A byte completes on the 8th rising edge.
- Detected STB fall: go to CMD, clear bit count. Detected STB rise (from any state): discard any partial byte, set tm_dio_oe = 0, go to IDLE, pulse frame_strobe if a RAM write occurred.
- CMD byte decode:
  - 0x40-0x7F (data command): bit1 = 1 selects read, 0 selects write; bit2 = 1 selects fixed address, 0 selects auto-increment. Mode persists across transactions. Read goes to READ; write goes to IGNORE for the rest of the transaction.
  - 0x80-0xBF (display control): display_on = bit3, brightness = bits[2:0]; then IGNORE.
  - 0xC0-0xFF (address set): address = bits[3:0]; go to WRITE.
  - 0x00-0x3F: IGNORE.
- WRITE: each completed byte is written to RAM[address]. In auto-increment mode, address is then incremented with wrap 15 -> 0. In fixed mode, address is unchanged.
- RAM mapping:
  - display(7-k) = RAM[2k].
  - leds[7-k] = RAM[2k+1][0]. Bits 7:1 of odd addresses are stored but not output.
  - Outputs update the cycle after the byte completes.
- READ:
  - keys are latched when the command byte completes.
  - tm_dio_oe goes to 1 on the next detected tm_clock fall. Bit 0 of read byte 0 is presented at that fall. Each following bit changes only on a detected fall.
  - Byte j (0..3): bit0 = keys[7-j], bit4 = keys[3-j], all other bits 0.
  - Bytes after the 4th read as 0x00.
  - tm_dio_oe stays 1 until STB rises.
- Simultaneous STB rise and tm_clock edge: the STB rise wins and the edge is ignored.
- Asserting reset mid-transaction aborts it immediately with all reset values applied.
- Clock edges while STB is high are ignored.

Decomposition:
- tm1638_pkg:
  - state enum: IDLE, CMD, WRITE, READ, IGNORE.
  - command-class constants: CMD_DATA = 2'b01, CMD_CTRL = 2'b10, CMD_ADDR = 2'b11 (bits 7:6).
  - data-command bit positions: READ_BIT = 1, FIXED_BIT = 2.
  - RAM depth constant 16.
- Sub-module tm1638_bit_shifter holds the synchronizers, edge detect, 8-bit RX shift register with bit counter and byte_done pulse, and the TX shift register loaded on demand and advanced on falls. The top-level FSM, RAM and output mapping stay in tm1638_responder.

Test Plan:
- Reset, then STB low, send 0x8D, STB high -> display_on = 1, brightness = 5, no frame_strobe, tm_dio_oe stayed 0.
- Send 0x40, then 0xC0 followed by 16 bytes (0x3F,0x01,0x06,0x00,...) -> display7 = 0x3F, leds[7] = 1, display6 = 0x06, leds[6] = 0; one frame_strobe at STB rise.
- Send 0x44, then 0xCE followed by 0x11, 0x22 -> RAM[14] = 0x22 (display0 = 0x22), RAM[15] untouched. Then 0x40 and 0xCF followed by 0x01, 0xAA -> leds[0] = 1, RAM[0] = 0xAA (wrap, display7 = 0xAA).
- keys = 0x81, send 0x42, clock 4 read bytes -> master receives 0x01, 0x00, 0x00, 0x10; tm_dio_oe = 1 only from the first post-command fall to the STB rise.
- Raise STB after 3 bits of a data byte in WRITE -> no RAM change, no frame_strobe; next transaction decodes normally.
- Assert reset mid-READ -> tm_dio_oe = 0 asynchronously; all outputs return to reset values.
- Loopback with ledandkey (CLICK_DIV_X2 = 16) -> display/leds outputs equal the controller inputs within 2 refresh frames, and the controller's keys equal the responder's keys.
